// File: rtl/mem_stage_sram_ctrl_if.sv
// Pipeline-side and SRAM-side signals of the MEM-stage SRAM controller.
// The slave modport is the controller; the master modport is the pipeline and SRAM it serves.
interface mem_stage_sram_ctrl_if #(
   parameter int unsigned WORD_WIDTH = 32,
   parameter int unsigned SRAM_AW    = 18,
   parameter int unsigned SRAM_DW    = 16
);
   logic                  mem_read;
   logic                  mem_write;
   logic [WORD_WIDTH-1:0] addr;
   logic [WORD_WIDTH-1:0] wdata;
   logic                  ready;
   logic [WORD_WIDTH-1:0] rdata;
   logic [SRAM_AW-1:0]    sram_addr;
   logic [SRAM_DW-1:0]    sram_dq_out;
   logic                  sram_dq_oe;
   logic [SRAM_DW-1:0]    sram_dq_in;
   logic                  sram_we_n;

   modport slave (
      input  mem_read, mem_write, addr, wdata, sram_dq_in,
      output ready, rdata, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
   );

   modport master (
      output mem_read, mem_write, addr, wdata, sram_dq_in,
      input  ready, rdata, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
   );
endinterface

// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage SRAM controller: each 32-bit load/store becomes two 16-bit SRAM
// accesses (low halfword then high halfword), each held for WAIT_CYCLES cycles.
// ready stays low while an access is in flight so earlier stages freeze.
module mem_stage_sram_ctrl #(
   parameter int unsigned WORD_WIDTH  = 32,
   parameter int unsigned SRAM_AW     = 18,
   parameter int unsigned SRAM_DW     = 16,
   parameter int unsigned ADDR_BASE   = 1024,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input logic                  clk,
   input logic                  rst,
   mem_stage_sram_ctrl_if.slave bus
);

   localparam int unsigned IDX_W = SRAM_AW - 1;
   localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LO,
      S_HI,
      S_DONE
   } state_e;

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  store_q, store_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [WORD_WIDTH-1:0] wdata_q, wdata_d;
   logic [WORD_WIDTH-1:0] rdata_q, rdata_d;

   logic                  req;
   logic                  phase_end;
   logic [WORD_WIDTH-1:0] addr_off;
   logic                  unused_addr_bits;

   // Request decode and word index of the byte address relative to the SRAM window.
   always_comb begin
      req              = bus.mem_read | bus.mem_write;
      addr_off         = bus.addr - WORD_WIDTH'(ADDR_BASE);
      phase_end        = (cnt_q == CNT_LAST);
      unused_addr_bits = ^{addr_off[WORD_WIDTH-1:IDX_W+2], addr_off[1:0]};
   end

   // State and captured-operand registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         store_q <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         store_q <= store_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   // Next state, wait counter, operand capture and load-data capture.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      store_d = store_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               state_d = S_LO;
               cnt_d   = '0;
               // mem_write wins when both request bits are set
               store_d = bus.mem_write;
               idx_d   = addr_off[2 +: IDX_W];
               wdata_d = bus.wdata;
            end
         end
         S_LO: begin
            if (phase_end) begin
               state_d = S_HI;
               cnt_d   = '0;
               if (!store_q) rdata_d[SRAM_DW-1:0] = bus.sram_dq_in;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_HI: begin
            if (phase_end) begin
               state_d = S_DONE;
               cnt_d   = '0;
               if (!store_q) rdata_d[WORD_WIDTH-1:SRAM_DW] = bus.sram_dq_in;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DONE: begin
            // the still-present request is the instruction just served
            state_d = S_IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs: SRAM bus from state and captured registers only; ready also sees req.
   always_comb begin
      bus.ready       = ((state_q == S_IDLE) && !req) || (state_q == S_DONE);
      bus.rdata       = rdata_q;
      bus.sram_addr   = '0;
      bus.sram_dq_out = '0;
      bus.sram_dq_oe  = 1'b0;
      bus.sram_we_n   = 1'b1;
      case (state_q)
         S_LO: begin
            bus.sram_addr   = {idx_q, 1'b0};
            bus.sram_dq_out = wdata_q[SRAM_DW-1:0];
            bus.sram_dq_oe  = store_q;
            bus.sram_we_n   = !store_q;
         end
         S_HI: begin
            bus.sram_addr   = {idx_q, 1'b1};
            bus.sram_dq_out = wdata_q[WORD_WIDTH-1:SRAM_DW];
            bus.sram_dq_oe  = store_q;
            bus.sram_we_n   = !store_q;
         end
         default: begin
         end
      endcase
   end

endmodule
